bus_ram_responder: RTL and testbench

Responder (target) end of the bmain bus protocol: a single-ported on-chip RAM that accepts read and write commands from bus initiators such as the fetch and memory stages. It serves every transaction as a fixed 4-beat line burst, which matches the cache line fill. Commands addressing outside its window get an error handshake instead of data. It sits behind the bmain interconnect as the main-memory target.

---
 rtl/bus_ram_responder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_bus_ram_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram_responder.sv
// -----------------------------------------------------------------------------
// bus_ram_responder
//   Target end of the bmain bus: a single-ported 32-bit RAM that serves every
//   command as a fixed 4-beat, line-wrapping burst. Commands outside the RAM
//   window drain their data (writes) and then raise an error handshake.
//
// Parameters
//   ADDR_BITS : word-address width of the RAM (2**ADDR_BITS words, >= 2)
//   BASE      : word address [28:2] of RAM word 0, aligned to 2**ADDR_BITS
//
// Ports
//   clk_core  in   core clock, rising edge
//   reset_n   in   synchronous active-low reset
//   cvalid    in   command valid          cready out  command accepted
//   cmd       in   1 = read, 0 = write    addr   in   word address [28:2]
//   rvalid    out  read beat valid        rready in   initiator takes beat
//   rlast     out  4th read beat          rdata  out  read data
//   wvalid    in   write beat valid       wready out  responder takes beat
//   wdata     in   write data             wstrb  in   byte enables
//   error     out  address error pending  eack   in   error acknowledge
//
// Build option
//   BUS_RAM_RANDOM_STALL_EN : when defined, a 16-bit Galois LFSR randomly
//   suppresses cready / rvalid / wready for single cycles.
// -----------------------------------------------------------------------------
module bus_ram_responder #(
  parameter int          ADDR_BITS = 12,
  parameter logic [26:0] BASE      = 27'h0
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        cvalid,
  output logic        cready,
  input  logic        cmd,
  input  logic [26:0] addr,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  output logic [31:0] rdata,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        error,
  input  logic        eack
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    WDRAIN = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam int                   WORDS     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LINE_MASK = ~ADDR_BITS'(2'd3);
  // One extra bit so BASE + window size cannot wrap at the top of the map.
  localparam logic [27:0]          WIN_LO    = {1'b0, BASE};
  localparam logic [27:0]          WIN_HI    = WIN_LO + (28'd1 << ADDR_BITS);

  logic [31:0]          mem [WORDS];

  state_t               state_r, state_nx;
  logic [1:0]           cnt_r, cnt_nx;
  logic [1:0]           start_r;
  logic [ADDR_BITS-1:0] line_base_r;

  logic                 cready_r, cready_nx;
  logic                 rvalid_r, rvalid_nx;
  logic                 rlast_r, rlast_nx;
  logic [31:0]          rdata_r;
  logic                 wready_r, wready_nx;
  logic                 error_r, error_nx;

  logic                 stall_s;
  logic                 cmd_hs_s, r_hs_s, w_hs_s, in_range_s;
  logic                 rd_load_s, ram_we_s;
  logic [ADDR_BITS-1:0] rd_idx_s, wr_idx_s;
  logic [1:0]           wr_off_s, rd_next_off_s;

`ifdef BUS_RAM_RANDOM_STALL_EN
  logic [15:0] lfsr_r;

  // Galois LFSR (taps 16,14,13,11) free-running every cycle, drives stalls.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign stall_s = lfsr_r[0];
`else
  assign stall_s = 1'b0;
`endif

  // Stalls only mask the handshake strobes; the registered beat underneath
  // is untouched, so a suppressed read beat reappears unchanged.
  assign cready = cready_r & ~stall_s;
  assign rvalid = rvalid_r & ~stall_s;
  assign wready = wready_r & ~stall_s;
  assign rlast  = rlast_r;
  assign rdata  = rdata_r;
  assign error  = error_r;

  assign cmd_hs_s   = cvalid & cready;
  assign r_hs_s     = rvalid & rready;
  assign w_hs_s     = wvalid & wready;
  assign in_range_s = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);

  // Burst offsets wrap modulo 4 inside the 16-byte line.
  assign wr_off_s      = start_r + cnt_r;
  assign rd_next_off_s = start_r + cnt_r + 2'd1;
  assign wr_idx_s      = line_base_r | ADDR_BITS'(wr_off_s);

  // Next-state and next-output decode for the burst FSM.
  always_comb begin
    state_nx  = state_r;
    cnt_nx    = cnt_r;
    cready_nx = 1'b0;
    rvalid_nx = 1'b0;
    rlast_nx  = 1'b0;
    wready_nx = 1'b0;
    error_nx  = 1'b0;
    rd_load_s = 1'b0;
    rd_idx_s  = '0;
    ram_we_s  = 1'b0;

    case (state_r)
      IDLE: begin
        cready_nx = 1'b1;
        if (cmd_hs_s) begin
          cready_nx = 1'b0;
          cnt_nx    = 2'd0;
          if (cmd && in_range_s) begin
            // Beat 0 is fetched straight from the incoming address so it is
            // valid in the cycle right after accept.
            state_nx  = READ;
            rvalid_nx = 1'b1;
            rd_load_s = 1'b1;
            rd_idx_s  = addr[ADDR_BITS-1:0];
          end else if (cmd) begin
            state_nx = ERR;
            error_nx = 1'b1;
          end else if (in_range_s) begin
            state_nx  = WRITE;
            wready_nx = 1'b1;
          end else begin
            state_nx  = WDRAIN;
            wready_nx = 1'b1;
          end
        end else begin
          state_nx = IDLE;
        end
      end

      READ: begin
        rvalid_nx = 1'b1;
        rlast_nx  = rlast_r;
        if (r_hs_s) begin
          if (cnt_r == 2'd3) begin
            state_nx  = IDLE;
            rvalid_nx = 1'b0;
            rlast_nx  = 1'b0;
            cready_nx = 1'b1;
          end else begin
            cnt_nx    = cnt_r + 2'd1;
            rlast_nx  = (cnt_r == 2'd2);
            rd_load_s = 1'b1;
            rd_idx_s  = line_base_r | ADDR_BITS'(rd_next_off_s);
          end
        end else begin
          cnt_nx = cnt_r;
        end
      end

      WRITE: begin
        wready_nx = 1'b1;
        if (w_hs_s) begin
          ram_we_s = 1'b1;
          if (cnt_r == 2'd3) begin
            state_nx  = IDLE;
            wready_nx = 1'b0;
            cready_nx = 1'b1;
          end else begin
            cnt_nx = cnt_r + 2'd1;
          end
        end else begin
          cnt_nx = cnt_r;
        end
      end

      WDRAIN: begin
        wready_nx = 1'b1;
        if (w_hs_s) begin
          if (cnt_r == 2'd3) begin
            state_nx  = ERR;
            wready_nx = 1'b0;
            error_nx  = 1'b1;
          end else begin
            cnt_nx = cnt_r + 2'd1;
          end
        end else begin
          cnt_nx = cnt_r;
        end
      end

      ERR: begin
        error_nx = 1'b1;
        if (eack) begin
          state_nx  = IDLE;
          error_nx  = 1'b0;
          cready_nx = 1'b1;
        end else begin
          state_nx = ERR;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, burst bookkeeping and registered bus outputs.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      start_r     <= 2'd0;
      line_base_r <= '0;
      cready_r    <= 1'b0;
      rvalid_r    <= 1'b0;
      rlast_r     <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      wready_r    <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r  <= state_nx;
      cnt_r    <= cnt_nx;
      cready_r <= cready_nx;
      rvalid_r <= rvalid_nx;
      rlast_r  <= rlast_nx;
      wready_r <= wready_nx;
      error_r  <= error_nx;
      if (cmd_hs_s) begin
        start_r     <= addr[1:0];
        line_base_r <= addr[ADDR_BITS-1:0] & LINE_MASK;
      end
      if (rd_load_s) begin
        rdata_r <= mem[rd_idx_s];
      end
    end
  end

  // RAM write port; contents survive reset, and no beat lands during reset.
  always_ff @(posedge clk_core) begin
    if (reset_n && ram_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[wr_idx_s][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_ram_responder.sv
module tb_bus_ram_responder;

  localparam logic [26:0] BASE_A = 27'h4000;

  logic        clk_core = 1'b0;
  logic        reset_n  = 1'b0;
  logic        cvalid   = 1'b0;
  logic        cready;
  logic        cmd      = 1'b0;
  logic [26:0] addr     = 27'h0;
  logic        rvalid;
  logic        rready   = 1'b0;
  logic        rlast;
  logic [31:0] rdata;
  logic        wvalid   = 1'b0;
  logic        wready;
  logic [31:0] wdata    = 32'h0;
  logic [3:0]  wstrb    = 4'h0;
  logic        error;
  logic        eack     = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_q [4];
  logic        rv_q [4];
  logic        rl_q [4];
  logic        rv_after, cr_after;

  bus_ram_responder #(.ADDR_BITS(12), .BASE(BASE_A)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .cvalid(cvalid), .cready(cready), .cmd(cmd), .addr(addr),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .error(error), .eack(eack)
  );

  always #5 clk_core = ~clk_core;

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  // Stimulus only: issue a write command and stream 4 beats (word i of d).
  task automatic write_line(input logic [26:0] a, input logic [127:0] d, input logic [3:0] s);
    cvalid = 1'b1; cmd = 1'b0; addr = a;
    tick();
    cvalid = 1'b0;
    wvalid = 1'b1; wstrb = s;
    for (int i = 0; i < 4; i++) begin
      wdata = d[32*i +: 32];
      tick();
    end
    wvalid = 1'b0;
  endtask

  // Stimulus only: issue a read with rready high and record each cycle.
  task automatic read_line(input logic [26:0] a);
    cvalid = 1'b1; cmd = 1'b1; addr = a; rready = 1'b1;
    tick();
    cvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rv_q[i] = rvalid; rd_q[i] = rdata; rl_q[i] = rlast;
      tick();
    end
    rv_after = rvalid; cr_after = cready;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    total++; if (cready !== 1'b0) begin bad++; $display("FAIL rst_cready got=%b want=0", cready); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", rvalid); end
    total++; if (rlast !== 1'b0) begin bad++; $display("FAIL rst_rlast got=%b want=0", rlast); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL rst_wready got=%b want=0", wready); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b want=0", error); end
    reset_n = 1'b1;
    tick();
    total++; if (cready !== 1'b1) begin bad++; $display("FAIL rst_release_cready got=%b want=1", cready); end
  endtask

  task automatic test_write_read();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    cvalid = 1'b1; cmd = 1'b0; addr = BASE_A + 27'd4;
    tick();
    cvalid = 1'b0;
    total++; if (wready !== 1'b1) begin bad++; $display("FAIL wr_wready got=%b want=1", wready); end
    total++; if (cready !== 1'b0) begin bad++; $display("FAIL wr_cready_busy got=%b want=0", cready); end
    wvalid = 1'b1; wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      wdata = exp_d[i];
      tick();
    end
    wvalid = 1'b0;
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL wr_wready_end got=%b want=0", wready); end
    read_line(BASE_A + 27'd4);
    for (int i = 0; i < 4; i++) begin
      total++; if (rv_q[i] !== 1'b1) begin bad++; $display("FAIL rd_rvalid[%0d] got=%b want=1", i, rv_q[i]); end
      total++; if (rd_q[i] !== exp_d[i]) begin bad++; $display("FAIL rd_data[%0d] got=%h want=%h", i, rd_q[i], exp_d[i]); end
      total++; if (rl_q[i] !== (i == 3)) begin bad++; $display("FAIL rd_rlast[%0d] got=%b want=%b", i, rl_q[i], (i == 3)); end
    end
    total++; if (rv_after !== 1'b0) begin bad++; $display("FAIL rd_rvalid_end got=%b want=0", rv_after); end
    total++; if (cr_after !== 1'b1) begin bad++; $display("FAIL rd_cready_end got=%b want=1", cr_after); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h33; exp_d[1] = 32'h44; exp_d[2] = 32'h11; exp_d[3] = 32'h22;
    read_line(BASE_A + 27'd6);
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_q[i] !== exp_d[i]) begin bad++; $display("FAIL wrap_data[%0d] got=%h want=%h", i, rd_q[i], exp_d[i]); end
    end
    total++; if (rl_q[3] !== 1'b1) begin bad++; $display("FAIL wrap_rlast got=%b want=1", rl_q[3]); end
  endtask

  task automatic test_strobe();
    write_line(BASE_A + 27'd8, {4{32'h1122_3344}}, 4'hF);
    write_line(BASE_A + 27'd8, {4{32'hAABB_CCDD}}, 4'b0101);
    read_line(BASE_A + 27'd8);
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_q[i] !== 32'h11BB_33DD) begin bad++; $display("FAIL strb_data[%0d] got=%h want=11bb33dd", i, rd_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic        pat   [8];
    logic        exp_v [8];
    logic [31:0] exp_d [8];
    int          beats, lasts;
    pat[0]=1; pat[1]=0; pat[2]=0; pat[3]=1; pat[4]=0; pat[5]=1; pat[6]=1; pat[7]=1;
    exp_d[0]=32'h11; exp_d[1]=32'h22; exp_d[2]=32'h22; exp_d[3]=32'h22;
    exp_d[4]=32'h33; exp_d[5]=32'h33; exp_d[6]=32'h44; exp_d[7]=32'h0;
    for (int c = 0; c < 8; c++) exp_v[c] = (c < 7);
    beats = 0; lasts = 0;
    cvalid = 1'b1; cmd = 1'b1; addr = BASE_A + 27'd4; rready = 1'b0;
    tick();
    cvalid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      rready = pat[c];
      total++; if (rvalid !== exp_v[c]) begin bad++; $display("FAIL bp_rvalid[%0d] got=%b want=%b", c, rvalid, exp_v[c]); end
      if (exp_v[c]) begin
        total++; if (rdata !== exp_d[c]) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", c, rdata, exp_d[c]); end
      end
      if (rvalid === 1'b1 && rready === 1'b1) begin
        beats++;
        if (rlast === 1'b1) lasts++;
      end
      tick();
    end
    rready = 1'b0;
    total++; if (beats != 4) begin bad++; $display("FAIL bp_beats got=%0d want=4", beats); end
    total++; if (lasts != 1) begin bad++; $display("FAIL bp_rlast_count got=%0d want=1", lasts); end
  endtask

  task automatic test_error();
    // Out-of-range read: error only, never rvalid.
    cvalid = 1'b1; cmd = 1'b1; addr = BASE_A + 27'h1000; rready = 1'b1;
    tick();
    cvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL err_rvalid[%0d] got=%b want=0", c, rvalid); end
      total++; if (error !== 1'b1) begin bad++; $display("FAIL err_error[%0d] got=%b want=1", c, error); end
      total++; if (cready !== 1'b0) begin bad++; $display("FAIL err_cready[%0d] got=%b want=0", c, cready); end
      tick();
    end
    eack = 1'b1;
    tick();
    eack = 1'b0; rready = 1'b0;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b want=0", error); end
    total++; if (cready !== 1'b1) begin bad++; $display("FAIL err_cready_back got=%b want=1", cready); end
    // Out-of-range write whose low bits alias a real line must not touch it.
    write_line(BASE_A + 27'hFFC, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4'hF);
    write_line(BASE_A - 27'd4, {4{32'hDEAD_BEEF}}, 4'hF);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL wdrain_error got=%b want=1", error); end
    total++; if (cready !== 1'b0) begin bad++; $display("FAIL wdrain_cready got=%b want=0", cready); end
    eack = 1'b1;
    tick();
    eack = 1'b0;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL wdrain_cleared got=%b want=0", error); end
    read_line(BASE_A + 27'hFFC);
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_q[i] !== 32'hC0 + 32'(i)) begin bad++; $display("FAIL wdrain_ram[%0d] got=%h want=%h", i, rd_q[i], 32'hC0 + 32'(i)); end
    end
  endtask

  task automatic test_reset_mid_write();
    write_line(BASE_A + 27'h10, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF);
    cvalid = 1'b1; cmd = 1'b0; addr = BASE_A + 27'h10;
    tick();
    cvalid = 1'b0;
    wvalid = 1'b1; wstrb = 4'hF;
    wdata = 32'hB0; tick();
    wdata = 32'hB1; tick();
    // Keep presenting beats through reset; none may land.
    reset_n = 1'b0; wdata = 32'hB2;
    tick();
    total++; if ({cready, rvalid, rlast, wready, error} !== 5'b0) begin bad++; $display("FAIL mid_rst_ctrl got=%b want=00000", {cready, rvalid, rlast, wready, error}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL mid_rst_rdata got=%h want=0", rdata); end
    wdata = 32'hB3;
    tick();
    reset_n = 1'b1; wvalid = 1'b0;
    tick();
    total++; if (cready !== 1'b1) begin bad++; $display("FAIL mid_rst_cready got=%b want=1", cready); end
    read_line(BASE_A + 27'h10);
    total++; if (rd_q[0] !== 32'hB0) begin bad++; $display("FAIL mid_rst_w0 got=%h want=b0", rd_q[0]); end
    total++; if (rd_q[1] !== 32'hB1) begin bad++; $display("FAIL mid_rst_w1 got=%h want=b1", rd_q[1]); end
    total++; if (rd_q[2] !== 32'hA2) begin bad++; $display("FAIL mid_rst_w2 got=%h want=a2", rd_q[2]); end
    total++; if (rd_q[3] !== 32'hA3) begin bad++; $display("FAIL mid_rst_w3 got=%h want=a3", rd_q[3]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_strobe();
    test_backpressure();
    test_error();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
